// File: rtl/mul_chain_sink.sv
// mul_chain_sink: restores signed products from the shift-add multiplier
// chain, accumulates NUM_TERMS of them plus a bias, and hands the partial
// sum downstream over a valid/ready register.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   mul_result     unsigned product magnitude (2*DW bits)
//   result_flag    product valid
//   signal_flag    product sign (1 = negative)
//   en_synch       chain enable; everything holds while low
//   bias           signed bias, added at the first term of a window
//   clear          synchronous window abort
//   out_data       signed partial sum
//   out_valid      out_data valid
//   out_ready      downstream accepts out_data
//   drop_err       sticky: a completed sum was lost to back-pressure
//   busy           a window is open
//   sat_flag       (MUL_SINK_SAT_EN only) saturation happened in the window
//
// Optional feature macro: MUL_SINK_SAT_EN (saturating accumulation).

module mul_chain_sink #(
  parameter int DW        = 8,
  parameter int ACC_W     = 24,
  parameter int NUM_TERMS = 25,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*DW-1:0]   mul_result,
  input  logic              result_flag,
  input  logic              signal_flag,
  input  logic              en_synch,
  input  logic [ACC_W-1:0]  bias,
  input  logic              clear,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drop_err,
`ifdef MUL_SINK_SAT_EN
  output logic              sat_flag,
`endif
  output logic              busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             drop_err_q, drop_err_d;

  logic             cap;
  logic             last_term;
  logic             complete;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;

  assign cap     = result_flag & en_synch & ~clear;
  assign mag_ext = ACC_W'(mul_result);
  assign prod    = signal_flag ? ({ACC_W{1'b0}} - mag_ext)
                               : mag_ext;

  // The bias stands in for the accumulator on the first term.
  assign base = (state_q == S_IDLE) ? bias : acc_q;

  // A one-term window finishes straight out of IDLE.
  assign last_term = (state_q == S_IDLE)
                   ? (NUM_TERMS == 1)
                   : (cnt_q == CNT_W'(NUM_TERMS - 1));

  assign complete = cap & last_term;

`ifdef MUL_SINK_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;
  logic           sat_now;
  logic           win_sat_q, win_sat_d;
  logic           sat_flag_q, sat_flag_d;

  // One extra bit exposes signed overflow as a sign disagreement.
  assign wide    = {base[ACC_W-1], base} + {prod[ACC_W-1], prod};
  assign sat_now = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum     = !sat_now ? wide[ACC_W-1:0]
                 : (wide[ACC_W] ? SAT_MIN : SAT_MAX);
`else
  assign sum = base + prod;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cap && !last_term) state_d = S_ACC;
      S_ACC:  if (complete || clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_ACC);
  end

  // Accumulator and term counter
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear || complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cap) begin
      acc_d = sum;
      cnt_d = (state_q == S_IDLE) ? CNT_W'(1)
                                  : cnt_q + CNT_W'(1);
    end
  end

  // Output register: an accept in the completing cycle frees the slot.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_err_d  = drop_err_q;
    if (en_synch) begin
      if (complete) begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = sum;
          out_valid_d = 1'b1;
        end else begin
          drop_err_d  = 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

`ifdef MUL_SINK_SAT_EN
  // Window saturation history, latched next to out_data.
  always_comb begin
    win_sat_d  = win_sat_q;
    sat_flag_d = sat_flag_q;
    if (clear || complete) begin
      win_sat_d = 1'b0;
    end else if (cap) begin
      win_sat_d = (state_q == S_IDLE) ? sat_now
                                      : (win_sat_q | sat_now);
    end
    if (complete && (!out_valid_q || out_ready)) begin
      sat_flag_d = (state_q == S_IDLE) ? sat_now
                                       : (win_sat_q | sat_now);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_sat_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      win_sat_q  <= win_sat_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_mul_chain_sink.sv
// Testbench for mul_chain_sink: directed windows checked against a
// term-list model every cycle, plus hand-computed literal results.

module tb_mul_chain_sink;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   mag;
  logic          rf;
  logic          sg;
  logic          en;
  logic [AW-1:0] bias;
  logic          clr;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          rdy;
  logic          drop_err;
  logic          busy;
`ifdef MUL_SINK_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  mul_chain_sink #(
    .DW(DW), .ACC_W(AW), .NUM_TERMS(NT), .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mul_result(mag),
    .result_flag(rf),
    .signal_flag(sg),
    .en_synch(en),
    .bias(bias),
    .clear(clr),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(rdy),
    .drop_err(drop_err),
`ifdef MUL_SINK_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: a window is a list of signed terms; its value is bias plus
  // their sum, reduced to AW bits (or clamped after each add).
  longint  m_sum;
  int      m_n;
  bit      m_open;
  bit      m_valid;
  bit      m_err;
  bit      m_wsat;
  bit      m_sat;
  logic [AW-1:0] m_out;

  localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW-1));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum = 0; m_n = 0; m_open = 0;
      m_valid = 0; m_err = 0; m_out = '0;
      m_wsat = 0; m_sat = 0;
    end else begin
      bit done;
      done = 0;
      if (clr) begin
        m_sum = 0; m_n = 0; m_open = 0; m_wsat = 0;
      end else if (en && rf) begin
        if (!m_open) begin
          m_sum  = longint'($signed(bias));
          m_wsat = 0;
        end
        m_sum = sg ? m_sum - longint'(mag) : m_sum + longint'(mag);
`ifdef MUL_SINK_SAT_EN
        if (m_sum > MAXV) begin m_sum = MAXV; m_wsat = 1; end
        if (m_sum < MINV) begin m_sum = MINV; m_wsat = 1; end
`endif
        m_n++;
        m_open = 1;
        if (m_n == NT) begin
          done = 1; m_n = 0; m_open = 0;
        end
      end
      if (en) begin
        if (done) begin
          if (!m_valid || rdy) begin
            m_out   = m_sum[AW-1:0];
            m_valid = 1;
            m_sat   = m_wsat;
          end else begin
            m_err = 1;
          end
        end else if (m_valid && rdy) begin
          m_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_data", 32'(out_data), 32'(m_out));
      chk("cyc_err", 32'(drop_err), 32'(m_err));
      chk("cyc_busy", 32'(busy), 32'(m_open));
`ifdef MUL_SINK_SAT_EN
      chk("cyc_sat", 32'(sat_flag), 32'(m_sat));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] m, input logic s);
    rf = 1'b1; mag = m; sg = s;
    tick();
    rf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rf = 1'b0; mag = '0; sg = 1'b0;
    en = 1'b1; clr = 1'b0; rdy = 1'b1; bias = '0;
    tick();
    tick();
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(drop_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic window: 10 + 100 - 50 + 3 - 0
    bias = 24'd10;
    put(100, 0); put(50, 1); put(3, 0);
    chk("basic_early", 32'(out_valid), 32'h0);
    put(0, 1);
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_data", 32'(out_data), 32'd63);
    tick();
    chk("basic_accept", 32'(out_valid), 32'h0);

    // Gaps and enable stall
    put(100, 0);
    tick();
    en = 1'b0; rf = 1'b1; mag = 16'd77; sg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_busy", 32'(busy), 32'h1);
    end
    en = 1'b1; rf = 1'b0;
    put(50, 1);
    tick();
    put(3, 0);
    chk("gap_busy", 32'(busy), 32'h1);
    chk("gap_early", 32'(out_valid), 32'h0);
    put(0, 1);
    chk("gap_data", 32'(out_data), 32'd63);
    chk("gap_valid", 32'(out_valid), 32'h1);
    tick();

    // Back-pressure drop
    rdy = 1'b0; bias = '0;
    for (int i = 0; i < 4; i++) put(1, 0);
    chk("bp_a_data", 32'(out_data), 32'd4);
    for (int i = 0; i < 4; i++) put(2, 0);
    chk("bp_b_data", 32'(out_data), 32'd4);
    chk("bp_err", 32'(drop_err), 32'h1);
    chk("bp_hold", 32'(out_valid), 32'h1);
    rdy = 1'b1;
    tick();
    chk("bp_release", 32'(out_valid), 32'h0);
    chk("bp_sticky", 32'(drop_err), 32'h1);
    do_reset();

    // Accept and completion in the same cycle
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) put(1, 0);
    chk("sim_a_data", 32'(out_data), 32'd4);
    for (int i = 0; i < 3; i++) put(2, 0);
    rdy = 1'b1;
    put(2, 0);
    chk("sim_data", 32'(out_data), 32'd8);
    chk("sim_valid", 32'(out_valid), 32'h1);
    chk("sim_err", 32'(drop_err), 32'h0);
    tick();

    // Clear aborts a window and drops the coincident product
    bias = 24'd10;
    put(7, 0); put(9, 0);
    clr = 1'b1; rf = 1'b1; mag = 16'd11;
    tick();
    clr = 1'b0; rf = 1'b0;
    chk("clr_busy", 32'(busy), 32'h0);
    bias = '0;
    for (int i = 0; i < 4; i++) put(5, 1);
    chk("clr_data", 32'(out_data), 32'hFFFFEC);
    tick();

    // Reset mid-window
    put(3, 0); put(3, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) put(3, 0);
    chk("fresh_data", 32'(out_data), 32'd12);
    tick();

    // Overflow: 0x7FFFFF + 4 * 65025
    bias = 24'h7FFFFF;
    for (int i = 0; i < 4; i++) put(16'd65025, 0);
`ifdef MUL_SINK_SAT_EN
    chk("ovf_sat_data", 32'(out_data), 32'h7FFFFF);
    chk("ovf_sat_flag", 32'(sat_flag), 32'h1);
`else
    chk("ovf_wrap_data", 32'(out_data), 32'h83F803);
`endif
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
